// File: rtl/decode_issue.sv
// decode_issue: decodes 16-bit instructions, forms the ALU operands, tracks pending
// register writes in a busy scoreboard, and issues one registered bundle per cycle
// over valid/ready. Optional macro DECODE_STALL_CNT_EN adds a saturating hazard-stall counter.
module decode_issue #(
    parameter int unsigned WIDTH   = 16,
    parameter int unsigned RADDR_W = 3
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    input  logic [15:0]        in_instr,
    output logic               in_ready,
    input  logic               flush,
    output logic [RADDR_W-1:0] rf_ra1,
    output logic [RADDR_W-1:0] rf_ra2,
    input  logic [WIDTH-1:0]   rf_rd1,
    input  logic [WIDTH-1:0]   rf_rd2,
    input  logic               wb_valid,
    input  logic [RADDR_W-1:0] wb_addr,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [2:0]         out_op,
    output logic [3:0]         out_alu_op,
    output logic [WIDTH-1:0]   out_s_1,
    output logic [WIDTH-1:0]   out_s_2,
    output logic [RADDR_W-1:0] out_rd,
    output logic [WIDTH-1:0]   out_store,
    output logic               out_illegal
`ifdef DECODE_STALL_CNT_EN
    ,
    output logic [15:0]        stall_count
`endif
);

    localparam int unsigned NREG = 1 << RADDR_W;

    localparam logic [2:0] OP_ALU  = 3'b000;
    localparam logic [2:0] OP_ADDI = 3'b001;
    localparam logic [2:0] OP_ILL  = 3'b010;
    localparam logic [2:0] OP_LUI  = 3'b011;
    localparam logic [2:0] OP_SW   = 3'b100;
    localparam logic [2:0] OP_LW   = 3'b101;
    localparam logic [2:0] OP_BR   = 3'b110;
    localparam logic [2:0] OP_JALR = 3'b111;

    if (WIDTH != 16 || RADDR_W != 3) begin : g_param_check
        $error("decode_issue supports only WIDTH=16 and RADDR_W=3");
    end

    typedef struct packed {
        logic [2:0]         op;
        logic [3:0]         alu_op;
        logic [WIDTH-1:0]   s_1;
        logic [WIDTH-1:0]   s_2;
        logic [RADDR_W-1:0] rd;
        logic [WIDTH-1:0]   store;
        logic               illegal;
    } bundle_t;

    logic [2:0]         op;
    logic [RADDR_W-1:0] ra, rb, rc;
    logic [3:0]         alu_op_f;
    logic [6:0]         imm7;
    logic [9:0]         imm10;
    logic [WIDTH-1:0]   imm7_sext;

    assign op        = in_instr[15:13];
    assign ra        = in_instr[12:10];
    assign rb        = in_instr[9:7];
    assign alu_op_f  = in_instr[6:3];
    assign rc        = in_instr[2:0];
    assign imm7      = in_instr[6:0];
    assign imm10     = in_instr[9:0];
    assign imm7_sext = {{(WIDTH-7){imm7[6]}}, imm7};

    // Register file read ports: sw reads its store data from rA on port 2
    assign rf_ra1 = rb;
    assign rf_ra2 = (op == OP_SW) ? ra : rc;

    bundle_t            dec;
    logic               use_ra, use_rb, use_rc, writes;
    logic [NREG-1:0]    busy_q, busy_d;
    logic               hazard, accept;
    bundle_t            bundle_q;

    // Instruction decode and operand formation
    always_comb begin
        dec     = '0;
        use_ra  = 1'b0;
        use_rb  = 1'b0;
        use_rc  = 1'b0;
        writes  = 1'b0;
        dec.op  = op;
        case (op)
            OP_ALU: begin
                dec.alu_op = alu_op_f;
                dec.s_1    = rf_rd1;
                dec.s_2    = rf_rd2;
                use_rb     = 1'b1;
                use_rc     = 1'b1;
                writes     = 1'b1;
            end
            OP_ADDI, OP_LW: begin
                dec.s_1 = rf_rd1;
                dec.s_2 = imm7_sext;
                use_rb  = 1'b1;
                writes  = 1'b1;
            end
            OP_SW: begin
                dec.s_1   = rf_rd1;
                dec.s_2   = imm7_sext;
                dec.store = rf_rd2;
                use_rb    = 1'b1;
                use_ra    = 1'b1;
            end
            OP_LUI: begin
                dec.s_1 = WIDTH'({imm10, 6'b0});
                writes  = 1'b1;
            end
            OP_JALR: begin
                dec.s_1 = rf_rd1;
                use_rb  = 1'b1;
                writes  = 1'b1;
            end
            OP_ILL: begin
                dec.illegal = 1'b1;
            end
            OP_BR: begin
            end
        endcase
        dec.rd = writes ? ra : '0;
    end

    // Hazard on any busy source or destination; busy[0] is never set
    assign hazard = (use_rb & busy_q[rb]) | (use_rc & busy_q[rc]) |
                    (use_ra & busy_q[ra]) | busy_q[dec.rd];

    assign in_ready = !rst && !flush && !hazard && (!out_valid || out_ready);
    assign accept   = in_valid && in_ready;

    // Busy scoreboard next state: writeback clears, a new issue sets (set wins)
    always_comb begin
        busy_d = busy_q;
        if (wb_valid) begin
            busy_d[wb_addr] = 1'b0;
        end
        if (accept) begin
            busy_d[dec.rd] = 1'b1;
        end
        busy_d[0] = 1'b0;
    end

    // Busy scoreboard register
    always_ff @(posedge clk) begin
        if (rst) begin
            busy_q <= '0;
        end else begin
            busy_q <= busy_d;
        end
    end

    // Output bundle register: capture on accept, hold while stalled, drop on flush
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            bundle_q  <= '0;
        end else if (flush) begin
            out_valid <= 1'b0;
        end else if (accept) begin
            out_valid <= 1'b1;
            bundle_q  <= dec;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

    assign out_op      = bundle_q.op;
    assign out_alu_op  = bundle_q.alu_op;
    assign out_s_1     = bundle_q.s_1;
    assign out_s_2     = bundle_q.s_2;
    assign out_rd      = bundle_q.rd;
    assign out_store   = bundle_q.store;
    assign out_illegal = bundle_q.illegal;

`ifdef DECODE_STALL_CNT_EN
    logic [15:0] stall_q;

    // Saturating count of cycles where a valid instruction waits on a hazard
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_q <= '0;
        end else if (in_valid && hazard && !flush && (stall_q != 16'hFFFF)) begin
            stall_q <= stall_q + 16'd1;
        end
    end

    assign stall_count = stall_q;
`endif

endmodule

// File: tb/tb_decode_issue.sv
// tb_decode_issue: randomized scoreboard bench for decode_issue with a directed preamble.
module tb_decode_issue;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic [15:0] in_instr;
    logic        in_ready;
    logic        flush;
    logic [2:0]  rf_ra1, rf_ra2;
    logic [15:0] rf_rd1, rf_rd2;
    logic        wb_valid;
    logic [2:0]  wb_addr;
    logic        out_valid;
    logic        out_ready;
    logic [2:0]  out_op;
    logic [3:0]  out_alu_op;
    logic [15:0] out_s_1, out_s_2, out_store;
    logic [2:0]  out_rd;
    logic        out_illegal;
`ifdef DECODE_STALL_CNT_EN
    logic [15:0] stall_count;
`endif

    decode_issue dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_instr(in_instr),
        .in_ready(in_ready), .flush(flush), .rf_ra1(rf_ra1), .rf_ra2(rf_ra2),
        .rf_rd1(rf_rd1), .rf_rd2(rf_rd2), .wb_valid(wb_valid), .wb_addr(wb_addr),
        .out_valid(out_valid), .out_ready(out_ready), .out_op(out_op),
        .out_alu_op(out_alu_op), .out_s_1(out_s_1), .out_s_2(out_s_2),
        .out_rd(out_rd), .out_store(out_store), .out_illegal(out_illegal)
`ifdef DECODE_STALL_CNT_EN
        , .stall_count(stall_count)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural register file; r0 always reads zero
    logic [15:0] regs [0:7];
    assign rf_rd1 = regs[rf_ra1];
    assign rf_rd2 = regs[rf_ra2];

    typedef struct {
        logic [2:0]  op;
        logic [3:0]  alu_op;
        logic [15:0] s1;
        logic [15:0] s2;
        logic [2:0]  rd;
        logic [15:0] store;
        logic        ill;
    } exp_t;

    exp_t        q[$];
    bit   [7:0]  pend;
    bit          mv;
    bit          clr_q;
    bit          chk_zero;
    int unsigned cnt_model;
    int          n_cmp = 0;
    int          n_bad = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int unsigned f_op(input logic [15:0] ins);
        return int'(ins[15:13]);
    endfunction

    // Destination of an instruction, 0 when it does not write a register
    function automatic int unsigned dest_of(input logic [15:0] ins);
        int unsigned o = f_op(ins);
        if (o == 0 || o == 1 || o == 3 || o == 5 || o == 7) return int'(ins[12:10]);
        return 0;
    endfunction

    // True when any register this instruction touches still has a write in flight
    function automatic bit hazard_of(input logic [15:0] ins);
        int unsigned o = f_op(ins);
        bit h = pend[dest_of(ins)];
        if (o == 0 || o == 1 || o == 4 || o == 5 || o == 7) h |= pend[ins[9:7]];
        if (o == 0) h |= pend[ins[2:0]];
        if (o == 4) h |= pend[ins[12:10]];
        return h;
    endfunction

    // Expected bundle from the instruction set semantics
    function automatic exp_t bundle_of(input logic [15:0] ins);
        exp_t e;
        int unsigned o = f_op(ins);
        int          imm = int'(ins[6:0]);
        if (imm >= 64) imm -= 128;
        e.op = ins[15:13]; e.alu_op = 4'd0; e.s1 = 16'd0; e.s2 = 16'd0;
        e.store = 16'd0; e.ill = 1'b0;
        e.rd = 3'(dest_of(ins));
        case (o)
            0: begin e.alu_op = ins[6:3]; e.s1 = regs[ins[9:7]]; e.s2 = regs[ins[2:0]]; end
            1, 5: begin e.s1 = regs[ins[9:7]]; e.s2 = 16'(imm); end
            4: begin e.s1 = regs[ins[9:7]]; e.s2 = 16'(imm); e.store = regs[ins[12:10]]; end
            3: e.s1 = 16'(int'(ins[9:0]) * 64);
            7: e.s1 = regs[ins[9:7]];
            2: e.ill = 1'b1;
            default: ;
        endcase
        return e;
    endfunction

    // One clock of stimulus plus reference-model update
    task automatic cycle(input bit r, input bit iv, input logic [15:0] ins, input bit ordy,
                         input bit fl, input bit wbv, input logic [2:0] wba, input bit rnd_reg);
        bit hz, er, acc;
        @(posedge clk);
        if (clr_q) begin q.delete(); clr_q = 0; end
        #1;
        if (chk_zero) begin
            check("reset_outs", 32'({out_valid, out_op, out_alu_op, out_rd, out_illegal}), 32'd0);
            check("reset_data", 32'(out_s_1 | out_s_2 | out_store), 32'd0);
            chk_zero = 0;
        end
        rst = r; in_valid = iv; in_instr = ins; out_ready = ordy; flush = fl;
        wb_valid = wbv; wb_addr = wba;
        if (rnd_reg && wbv && wba != 3'd0) regs[wba] = 16'($urandom);
        #3;
        check("out_valid", 32'(out_valid), 32'(mv));
`ifdef DECODE_STALL_CNT_EN
        check("stall_count", 32'(stall_count), cnt_model);
`endif
        if (r) begin
            check("in_ready_rst", 32'(in_ready), 32'd0);
            pend = '0; mv = 0; clr_q = 1; chk_zero = 1; cnt_model = 0;
        end else begin
            hz  = hazard_of(ins);
            er  = !fl && !hz && (!mv || ordy);
            acc = iv && er;
            check("in_ready", 32'(in_ready), 32'(er));
            if (iv && hz && !fl && cnt_model != 32'hFFFF) cnt_model++;
            if (fl) mv = 0;
            else if (acc) begin mv = 1; q.push_back(bundle_of(ins)); end
            else if (ordy) mv = 0;
            if (wbv && wba != 3'd0) pend[wba] = 1'b0;
            if (acc && dest_of(ins) != 0) pend[dest_of(ins)] = 1'b1;
        end
    endtask

    // Monitor: compare every presented bundle with the scoreboard head
    always @(negedge clk) begin
        if (out_valid) begin
            if (q.size() == 0) begin
                n_cmp++; n_bad++;
                $display("FAIL unexpected_bundle: got op %h rd %h expected none at %0t",
                         out_op, out_rd, $time);
            end else begin
                check("op", 32'(out_op), 32'(q[0].op));
                check("alu_op", 32'(out_alu_op), 32'(q[0].alu_op));
                check("s_1", 32'(out_s_1), 32'(q[0].s1));
                check("s_2", 32'(out_s_2), 32'(q[0].s2));
                check("rd", 32'(out_rd), 32'(q[0].rd));
                check("store", 32'(out_store), 32'(q[0].store));
                check("illegal", 32'(out_illegal), 32'(q[0].ill));
                if (out_ready || flush) void'(q.pop_front());
            end
        end
    end

    initial begin
        rst = 1'b1; in_valid = 1'b0; in_instr = 16'd0; out_ready = 1'b0; flush = 1'b0;
        wb_valid = 1'b0; wb_addr = 3'd0;
        pend = '0; mv = 0; clr_q = 0; chk_zero = 0; cnt_model = 0;
        for (int i = 0; i < 8; i++) regs[i] = 16'd0;
        regs[2] = 16'd7; regs[3] = 16'd9; regs[1] = 16'h1234;

        // reset
        cycle(1, 0, 16'h0000, 0, 0, 0, 3'd0, 0);
        cycle(1, 0, 16'h0000, 0, 0, 0, 3'd0, 0);
        // add r1,r2,r3 then retire r1
        cycle(0, 1, 16'h050B, 1, 0, 0, 3'd0, 0);
        cycle(0, 0, 16'h0000, 1, 0, 1, 3'd1, 0);
        // addi r1,r0,-1 ; lui r2,0x3FF
        cycle(0, 1, 16'h247F, 1, 0, 0, 3'd0, 0);
        cycle(0, 1, 16'h6BFF, 1, 0, 1, 3'd1, 0);
        cycle(0, 0, 16'h0000, 1, 0, 1, 3'd2, 0);
        // lw r1,r2,5 then dependent add r3,r1,r1 stalls until r1 retires
        cycle(0, 1, 16'hA505, 1, 0, 0, 3'd0, 0);
        for (int i = 0; i < 3; i++) cycle(0, 1, 16'h0C89, 1, 0, 0, 3'd0, 0);
        cycle(0, 1, 16'h0C89, 1, 0, 1, 3'd1, 0);
        cycle(0, 1, 16'h0C89, 1, 0, 0, 3'd0, 0);
        // illegal op, then hold with out_ready low, then flush
        cycle(0, 1, 16'h4000, 1, 0, 0, 3'd0, 0);
        for (int i = 0; i < 3; i++) cycle(0, 1, 16'h4000, 0, 0, 0, 3'd0, 0);
        cycle(0, 1, 16'h4000, 0, 1, 0, 3'd0, 0);
        // r3 still busy after flush: add r4,r3,r0 must stall, then reset mid-stall
        cycle(0, 1, 16'h1180, 1, 0, 0, 3'd0, 0);
        cycle(0, 1, 16'h1180, 1, 0, 0, 3'd0, 0);
        cycle(1, 1, 16'h1180, 0, 0, 0, 3'd0, 0);
        cycle(0, 1, 16'h1180, 1, 0, 0, 3'd0, 0);
        cycle(0, 0, 16'h0000, 1, 0, 1, 3'd4, 0);

        // randomized traffic
        for (int i = 0; i < 3000; i++) begin
            bit r, iv, fl, ordy, wbv;
            logic [2:0] wba;
            r    = ($urandom_range(0, 99) < 2);
            iv   = ($urandom_range(0, 9) < 7);
            fl   = !r && ($urandom_range(0, 99) < 5);
            ordy = !r && !fl && ($urandom_range(0, 9) < 6);
            wbv  = ($urandom_range(0, 9) < 3);
            wba  = 3'($urandom_range(0, 7));
            cycle(r, iv, 16'($urandom), ordy, fl, wbv, wba, 1);
        end

        // drain
        for (int i = 0; i < 4; i++) cycle(0, 0, 16'h0000, 1, 0, 0, 3'd0, 0);
        check("queue_empty", 32'(q.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
